bus_ram: RTL and testbench
==========================

# bus_ram

Memory-side responder for the 8-bit CPU bus: a 256 x 8 synchronous RAM that answers the CPU's `read`/`write` strobes and returns a one-cycle `ready` pulse after a programmable number of wait states. It sits directly on the CPU's address and data buses and is the CPU's only memory in the minimal system. Accesses are single-beat with no pipelining and no interrupts. The address and write data are latched at acceptance, so bus changes after acceptance have no effect.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: wait states inserted before `ready`; legal range 0..15.
- `ROM_LIMIT`, default 8'h40: first writable address. Used only when `BUS_RAM_WRITE_PROTECT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  8  byte address from the CPU.
- `data_in`  in  8  write data, driven by the CPU's `data_out`.
- `data_out`  out  8  read data, driving the CPU's `data_in`.
- `read`  in  1  read strobe.
- `write`  in  1  write strobe.
- `ready`  out  1  access-complete pulse.

## Operation
- FSM states:
  - IDLE. Strobes are sampled only in this state.
  - BUSY. Counts down wait states.
  - ACK. `ready`=1.
- IDLE:
  - Exactly one of `read`/`write` high: latch `address`, `data_in` and the op, and load `cnt`=WAIT_CYCLES.
  - Next state is BUSY if WAIT_CYCLES>0; otherwise the access is performed at this edge and the next state is ACK.
  - Both strobes high, or neither: stay IDLE with no access and no `ready`.
- BUSY:
  - `cnt`>1: decrement `cnt`.
  - `cnt`==1: perform the access and go to ACK.
- Access:
  - Read: `data_out` <= mem[latched addr], registered at the edge entering ACK.
  - Write: mem[latched addr] <= latched data at the edge entering ACK; `data_out` unchanged.
- ACK: `ready`=1 for exactly one cycle, then unconditionally IDLE.
- ACK→IDLE returns with no gap cycle. If a strobe is still high in the IDLE cycle, it starts a new access. The CPU therefore drops its strobe in the cycle after it samples `ready`.
- `data_out` holds the last read value until the next read completes or reset.
- `cnt` is 4 bits and never wraps; it is not decremented below 1 in BUSY.

## Timing
- Reset values:
  - `ready`=0.
  - `data_out`=8'h00.
  - State IDLE, `cnt`=0, latches cleared.
  - The RAM array is not reset; contents persist across reset.
- Latency: a strobe first sampled at edge k gives `ready` high in the cycle after edge k+WAIT_CYCLES. With WAIT_CYCLES=W, `ready` appears W+1 cycles after the strobe is first seen.
- Read data is valid in the same cycle `ready` is high.
- Throughput: one access per W+2 cycles when strobes are held back-to-back.
- Reset mid-access, in BUSY or ACK: return to IDLE next edge with `ready`=0. A pending write not yet committed is dropped. A write already committed in ACK stays.
- Changes to `address`/`data_in` during BUSY are ignored.
- A strobe deasserted during BUSY does not abort the access; `ready` still pulses.

## Configuration
- `BUS_RAM_WRITE_PROTECT_EN` defined:
  - Writes with latched address < `ROM_LIMIT` are discarded.
  - The access still completes with normal timing and a `ready` pulse.
  - Reads are unaffected.
- Undefined: all 256 locations are writable, and `ROM_LIMIT` is ignored.

## Test plan
- Reset with `read` held high for 3 cycles → `ready`=0 and `data_out`=8'h00 throughout. In the first cycle after reset deasserts, the held `read` is accepted as a new access.
- WAIT_CYCLES=1: write 8'hA5 to 8'h80, then read 8'h80:
  - `ready` is high 2 cycles after each strobe is first sampled.
  - The read returns `data_out`=8'hA5 in the `ready` cycle.
- WAIT_CYCLES=0: back-to-back held `read` at 8'h10, then 8'h11 (preloaded 8'h01, 8'h02) → `ready` pulses every 2nd cycle, with data 8'h01 then 8'h02.
- `read` and `write` both high for 4 cycles → no `ready`, memory and `data_out` unchanged, FSM stays IDLE.
- WAIT_CYCLES=3, write 8'h5A to 8'h90, with `reset` asserted in the 2nd BUSY cycle → no `ready`. A subsequent read of 8'h90 returns the old value.
- With `BUS_RAM_WRITE_PROTECT_EN`:
  - Write 8'hFF to 8'h3F → `ready` pulses; a read of 8'h3F returns the old value.
  - Write 8'hFF to 8'h40 → a read of 8'h40 returns 8'hFF.

Source files
------------

// File: rtl/bus_ram_if.sv
// CPU-side bus bundle for bus_ram: address, write data, read data, strobes and ready.
// The CPU owns the master modport; the RAM responder owns the slave modport.
interface bus_ram_if;
   logic [7:0] address;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       read;
   logic       write;
   logic       ready;

   modport master (
      output address, data_in, read, write,
      input  data_out, ready
   );

   modport slave (
      input  address, data_in, read, write,
      output data_out, ready
   );
endinterface

// File: rtl/bus_ram.sv
// bus_ram: 256 x 8 synchronous RAM responding to single-beat CPU read/write strobes,
// with WAIT_CYCLES wait states before a one-cycle ready pulse.
// Optional write protection of addresses below ROM_LIMIT: define BUS_RAM_WRITE_PROTECT_EN.
module bus_ram #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [7:0]  ROM_LIMIT   = 8'h40
) (
   input  logic     clk,
   input  logic     reset,
   bus_ram_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      ACK
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);

`ifdef BUS_RAM_WRITE_PROTECT_EN
   localparam bit PROTECT = 1'b1;
`else
   localparam bit PROTECT = 1'b0;
`endif

   state_t     state;
   state_t     state_next;
   logic [3:0] cnt;
   logic [7:0] addr_q;
   logic [7:0] data_q;
   logic       wr_q;
   logic [7:0] mem [256];

   logic       accept;
   logic       commit;
   logic       acc_wr;
   logic       wr_allow;
   logic [7:0] acc_addr;
   logic [7:0] acc_data;

   // Exactly one strobe seen in IDLE starts an access.
   always_comb begin
      accept = (state == IDLE) && (bus.read ^ bus.write);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = ZERO_WAIT ? ACK : BUSY;
         BUSY: if (cnt <= 4'd1) state_next = ACK;
         ACK:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode: ready is high for the whole ACK cycle.
   always_comb begin
      bus.ready = (state == ACK);
   end

   // Commit point and operands; with zero wait states the access happens on the
   // accepting edge itself, so the live bus is used instead of the latches.
   always_comb begin
      commit   = 1'b0;
      acc_addr = addr_q;
      acc_data = data_q;
      acc_wr   = wr_q;
      if (state == IDLE) begin
         acc_addr = bus.address;
         acc_data = bus.data_in;
         acc_wr   = bus.write;
         commit   = accept && ZERO_WAIT;
      end else if (state == BUSY) begin
         commit = (cnt <= 4'd1);
      end
   end

   // Write permission for the access being committed.
   always_comb begin
      wr_allow = !PROTECT || (acc_addr >= ROM_LIMIT);
   end

   // Request latches, wait-state counter and registered read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt          <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         wr_q         <= 1'b0;
         bus.data_out <= '0;
      end else begin
         if (accept) begin
            addr_q <= bus.address;
            data_q <= bus.data_in;
            wr_q   <= bus.write;
            cnt    <= WAIT_INIT;
         end else if ((state == BUSY) && (cnt > 4'd1)) begin
            cnt <= cnt - 4'd1;
         end
         if (commit && !acc_wr) bus.data_out <= mem[acc_addr];
      end
   end

   // RAM array write port; contents are not reset and a reset edge drops a pending write.
   always_ff @(posedge clk) begin
      if (!reset && commit && acc_wr && wr_allow) mem[acc_addr] <= acc_data;
   end

endmodule

// File: tb/tb_bus_ram.sv
// Directed bench for bus_ram with three instances: WAIT_CYCLES = 0, 1 and 3.
// Extra write-protect vectors are compiled in when BUS_RAM_WRITE_PROTECT_EN is defined.
module tb_bus_ram;

   logic       clk;
   logic [2:0] rst;
   logic [2:0] rd;
   logic [2:0] wr;
   logic [7:0] addr_s;
   logic [7:0] din_s;
   logic [7:0] exp_dout [3];

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   bus_ram_if b0 ();
   bus_ram_if b1 ();
   bus_ram_if b2 ();

   assign b0.address = addr_s;
   assign b0.data_in = din_s;
   assign b0.read    = rd[0];
   assign b0.write   = wr[0];
   assign b1.address = addr_s;
   assign b1.data_in = din_s;
   assign b1.read    = rd[1];
   assign b1.write   = wr[1];
   assign b2.address = addr_s;
   assign b2.data_in = din_s;
   assign b2.read    = rd[2];
   assign b2.write   = wr[2];

   bus_ram #(.WAIT_CYCLES(0), .ROM_LIMIT(8'h00)) u_ram_w0 (.clk(clk), .reset(rst[0]), .bus(b0));
   bus_ram #(.WAIT_CYCLES(1), .ROM_LIMIT(8'h40)) u_ram_w1 (.clk(clk), .reset(rst[1]), .bus(b1));
   bus_ram #(.WAIT_CYCLES(3), .ROM_LIMIT(8'h00)) u_ram_w3 (.clk(clk), .reset(rst[2]), .bus(b2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   function automatic logic rdy(input int d);
      case (d)
         0:       return b0.ready;
         1:       return b1.ready;
         default: return b2.ready;
      endcase
   endfunction

   function automatic logic [7:0] dout(input int d);
      case (d)
         0:       return b0.data_out;
         1:       return b1.data_out;
         default: return b2.data_out;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // One access on instance d; strobe and bus are dropped/scrambled right after acceptance.
   task automatic access(input int d, input bit is_wr, input logic [7:0] a,
                         input logic [7:0] dat, input logic [7:0] exp_rd, input int unsigned w);
      @(negedge clk);
      addr_s = a;
      din_s  = dat;
      if (is_wr) wr[d] = 1'b1;
      else       rd[d] = 1'b1;
      for (int unsigned n = 1; n <= w + 1; n++) begin
         @(negedge clk);
         if (n == 1) begin
            rd[d]  = 1'b0;
            wr[d]  = 1'b0;
            addr_s = ~a;
            din_s  = ~dat;
         end
         check(is_wr ? "wr_ready" : "rd_ready", {7'b0, rdy(d)}, {7'b0, (n == w + 1)});
      end
      if (!is_wr) exp_dout[d] = exp_rd;
      check(is_wr ? "wr_dout_hold" : "rd_data", dout(d), exp_dout[d]);
      @(negedge clk);
      check("idle_ready", {7'b0, rdy(d)}, 8'h00);
   endtask

   initial begin
`ifdef BUS_RAM_WRITE_PROTECT_EN
      logic [7:0] old_3f;
`endif
      rst    = '1;
      rd     = '0;
      wr     = '0;
      addr_s = '0;
      din_s  = '0;
      for (int i = 0; i < 3; i++) exp_dout[i] = 8'h00;

      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("por_ready", {7'b0, rdy(d)}, 8'h00);
         check("por_dout", dout(d), 8'h00);
      end
      rst = '0;

      // WAIT_CYCLES=1: write then read back
      access(1, 1'b1, 8'h80, 8'hA5, 8'h00, 1);
      access(1, 1'b0, 8'h80, 8'h00, 8'hA5, 1);

      // Reset with read held high for 3 cycles; the held read is taken once reset drops
      @(negedge clk);
      rst[1] = 1'b1;
      rd[1]  = 1'b1;
      addr_s = 8'h80;
      exp_dout[1] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_ready", {7'b0, rdy(1)}, 8'h00);
         check("rst_dout", dout(1), 8'h00);
      end
      rst[1] = 1'b0;
      @(negedge clk);
      check("post_rst_busy", {7'b0, rdy(1)}, 8'h00);
      @(negedge clk);
      check("post_rst_ready", {7'b0, rdy(1)}, 8'h01);
      check("post_rst_data", dout(1), 8'hA5);
      exp_dout[1] = 8'hA5;
      rd[1] = 1'b0;
      @(negedge clk);
      check("post_rst_idle", {7'b0, rdy(1)}, 8'h00);

      // WAIT_CYCLES=0: preload, then back-to-back held reads
      access(0, 1'b1, 8'h10, 8'h01, 8'h00, 0);
      access(0, 1'b1, 8'h11, 8'h02, 8'h00, 0);
      @(negedge clk);
      addr_s = 8'h10;
      rd[0]  = 1'b1;
      @(negedge clk);
      check("b2b_ready1", {7'b0, rdy(0)}, 8'h01);
      check("b2b_data1", dout(0), 8'h01);
      addr_s = 8'h11;
      @(negedge clk);
      check("b2b_gap", {7'b0, rdy(0)}, 8'h00);
      @(negedge clk);
      check("b2b_ready2", {7'b0, rdy(0)}, 8'h01);
      check("b2b_data2", dout(0), 8'h02);
      exp_dout[0] = 8'h02;
      rd[0] = 1'b0;
      @(negedge clk);
      check("b2b_idle", {7'b0, rdy(0)}, 8'h00);

      // Both strobes high: no access
      rd[0]  = 1'b1;
      wr[0]  = 1'b1;
      addr_s = 8'h10;
      din_s  = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("both_ready", {7'b0, rdy(0)}, 8'h00);
         check("both_dout", dout(0), 8'h02);
      end
      rd[0] = 1'b0;
      wr[0] = 1'b0;
      access(0, 1'b0, 8'h10, 8'h00, 8'h01, 0);

      // WAIT_CYCLES=3: reset during second BUSY cycle drops the pending write
      access(2, 1'b1, 8'h90, 8'h33, 8'h00, 3);
      @(negedge clk);
      addr_s = 8'h90;
      din_s  = 8'h5A;
      wr[2]  = 1'b1;
      @(negedge clk);
      check("abort_busy1", {7'b0, rdy(2)}, 8'h00);
      @(negedge clk);
      check("abort_busy2", {7'b0, rdy(2)}, 8'h00);
      rst[2] = 1'b1;
      wr[2]  = 1'b0;
      @(negedge clk);
      check("abort_rst", {7'b0, rdy(2)}, 8'h00);
      rst[2] = 1'b0;
      exp_dout[2] = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_ready", {7'b0, rdy(2)}, 8'h00);
      end
      access(2, 1'b0, 8'h90, 8'h00, 8'h33, 3);

`ifdef BUS_RAM_WRITE_PROTECT_EN
      // Capture the current content of 8'h3F, then try to overwrite it
      @(negedge clk);
      addr_s = 8'h3F;
      rd[1]  = 1'b1;
      @(negedge clk);
      rd[1] = 1'b0;
      @(negedge clk);
      old_3f = dout(1);
      exp_dout[1] = old_3f;
      @(negedge clk);
      access(1, 1'b1, 8'h3F, 8'hFF, 8'h00, 1);
      access(1, 1'b0, 8'h3F, 8'h00, old_3f, 1);
      access(1, 1'b1, 8'h40, 8'hFF, 8'h00, 1);
      access(1, 1'b0, 8'h40, 8'h00, 8'hFF, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
